// File: rtl/mole_link_host.sv
// Host-side link controller for the whack-a-mole game: decodes bytes from the
// remote board, tracks game state and queues command bytes toward the UART.
module mole_link_host #(
  parameter int START_TIMEOUT = 200_000_000,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       start_req,
  input  logic       click_valid,
  input  logic [2:0] click_idx,
  output logic [4:0] mole_onehot,
  output logic [7:0] hit_count,
  output logic [1:0] link_state,
  output logic       proto_err
);

  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [7:0] CODE_S = 8'h53;
  localparam logic [7:0] CODE_H = 8'h48;
  localparam logic [7:0] CODE_R = 8'h52;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STARTING = 2'd1,
    ST_PLAYING  = 2'd2,
    ST_OVER     = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      mole_q, mole_d;
  logic [7:0]      hit_q, hit_d;
  logic            err_q, err_d;
  logic            armed_q, armed_d;
  logic [TW-1:0]   timeout_q, timeout_d;
  logic [1:0]      guard_q, guard_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;

  state_t     eff_state;
  logic       start_ok;
  logic       is_digit;
  logic       rx_resolves_start;
  logic       click_hit;
  logic       push;
  logic [7:0] push_byte;
  logic       pop;
  logic       full;
  logic       push_ok;

  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign mole_onehot = mole_q;
  assign hit_count   = hit_q;
  assign link_state  = state_q;
  assign proto_err   = err_q;

  // Next-state computation for the game FSM, scoreboard and TX queue.
  always_comb begin
    state_d    = state_q;
    mole_d     = mole_q;
    hit_d      = hit_q;
    err_d      = err_q;
    armed_d    = armed_q;
    timeout_d  = timeout_q;
    guard_d    = guard_q;
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    push       = 1'b0;
    push_byte  = CODE_H;
    eff_state  = state_q;

    start_ok = start_req && ((state_q == ST_IDLE) || (state_q == ST_OVER));
    is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h34);
    rx_resolves_start = rx_ready && (is_digit || (rx_data == CODE_R));

    // Click is judged against the mole as it stood before this cycle's rx byte.
    click_hit = (state_q == ST_PLAYING) && click_valid && armed_q &&
                (mole_q != 5'd0) && (mole_q == (5'd1 << click_idx));

    if (start_ok) begin
      push      = 1'b1;
      push_byte = CODE_S;
      hit_d     = 8'd0;
      mole_d    = 5'd0;
      err_d     = 1'b0;
      armed_d   = 1'b0;
      timeout_d = TW'(START_TIMEOUT);
      state_d   = ST_STARTING;
      eff_state = ST_STARTING;
    end else if (state_q == ST_STARTING) begin
      timeout_d = (timeout_q > TW'(0)) ? (timeout_q - TW'(1)) : TW'(0);
      if ((timeout_q <= TW'(1)) && !rx_resolves_start) begin
        state_d = ST_IDLE;
        err_d   = 1'b1;
      end else begin
        state_d = state_q;
      end
    end else begin
      timeout_d = timeout_q;
    end

    if (click_hit) begin
      push      = 1'b1;
      push_byte = CODE_H;
      armed_d   = 1'b0;
    end else begin
      armed_d = armed_d;
    end

    if (rx_ready) begin
      if (is_digit) begin
        if ((eff_state == ST_STARTING) || (eff_state == ST_PLAYING)) begin
          mole_d  = 5'd1 << rx_data[2:0];
          armed_d = 1'b1;
          state_d = ST_PLAYING;
        end else begin
          mole_d = mole_d;
        end
      end else begin
        case (rx_data)
          CODE_S: err_d = err_d;
          CODE_H: begin
            if (eff_state == ST_PLAYING) begin
              hit_d = (hit_q == 8'hFF) ? hit_q : (hit_q + 8'd1);
            end else begin
              hit_d = hit_d;
            end
          end
          CODE_R: begin
            if (eff_state == ST_PLAYING) begin
              state_d = ST_OVER;
              mole_d  = 5'd0;
              armed_d = 1'b0;
            end else if (eff_state == ST_STARTING) begin
              state_d = ST_OVER;
              err_d   = 1'b1;
            end else begin
              state_d = state_d;
            end
          end
          default: err_d = 1'b1;
        endcase
      end
    end else begin
      err_d = err_d;
    end

    // TX queue: issue only when the transmitter and the post-issue guard allow.
    pop     = (count_q != (AW+1)'(0)) && !tx_busy && (guard_q == 2'd0);
    full    = (count_q == (AW+1)'(FIFO_DEPTH));
    push_ok = push && (!full || pop);

    if (push && !push_ok) begin
      err_d = 1'b1;
    end else begin
      err_d = err_d;
    end

    if (push_ok) begin
      mem_d[wr_ptr_q] = push_byte;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      guard_d  = 2'd2;
    end else begin
      rd_ptr_d = rd_ptr_q;
      guard_d  = (guard_q != 2'd0) ? (guard_q - 2'd1) : 2'd0;
    end

    count_d    = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
    tx_start_d = pop;
    tx_data_d  = pop ? mem_q[rd_ptr_q] : tx_data_q;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      mole_q     <= 5'd0;
      hit_q      <= 8'd0;
      err_q      <= 1'b0;
      armed_q    <= 1'b0;
      timeout_q  <= TW'(0);
      guard_q    <= 2'd0;
      rd_ptr_q   <= AW'(0);
      wr_ptr_q   <= AW'(0);
      count_q    <= (AW+1)'(0);
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'd0;
      end
    end else begin
      state_q    <= state_d;
      mole_q     <= mole_d;
      hit_q      <= hit_d;
      err_q      <= err_d;
      armed_q    <= armed_d;
      timeout_q  <= timeout_d;
      guard_q    <= guard_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      mem_q      <= mem_d;
    end
  end

endmodule

// File: tb/tb_mole_link_host.sv
// Directed bench for mole_link_host: a vector table for per-cycle behaviour
// plus hand-written sequences for timeout, saturation, overflow and reset.
module tb_mole_link_host;

  logic       clock;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       start_req;
  logic       click_valid;
  logic [2:0] click_idx;
  logic [4:0] mole_onehot;
  logic [7:0] hit_count;
  logic [1:0] link_state;
  logic       proto_err;

  int n_tests = 0;
  int n_fail  = 0;

  mole_link_host #(.START_TIMEOUT(10), .FIFO_DEPTH(2)) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .start_req(start_req), .click_valid(click_valid), .click_idx(click_idx),
    .mole_onehot(mole_onehot), .hit_count(hit_count),
    .link_state(link_state), .proto_err(proto_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       s;
    logic       rr;
    logic [7:0] rd;
    logic       cv;
    logic [2:0] ci;
    logic       b;
    logic       ts;
    logic [7:0] td;
    logic [4:0] mole;
    logic [7:0] hit;
    logic [1:0] st;
    logic       err;
  } vec_t;

  vec_t vecs[29];

  function automatic vec_t mk(input logic s, input logic rr, input logic [7:0] rd,
                              input logic cv, input logic [2:0] ci, input logic b,
                              input logic ts, input logic [7:0] td, input logic [4:0] mole,
                              input logic [7:0] hit, input logic [1:0] st, input logic err);
    vec_t v;
    v.s = s; v.rr = rr; v.rd = rd; v.cv = cv; v.ci = ci; v.b = b;
    v.ts = ts; v.td = td; v.mole = mole; v.hit = hit; v.st = st; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic rr, input logic [7:0] rd,
                       input logic cv, input logic [2:0] ci, input logic b);
    start_req = s; rx_ready = rr; rx_data = rd;
    click_valid = cv; click_idx = ci; tx_busy = b;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    chk({tag, "_mole"}, 32'(mole_onehot), 32'd0);
    chk({tag, "_hit"}, 32'(hit_count), 32'd0);
    chk({tag, "_state"}, 32'(link_state), 32'd0);
    chk({tag, "_err"}, 32'(proto_err), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int starts;
    int first_at;
    int last_at;
    int min_gap;
    logic [7:0] bytes_seen [2];

    //           s  rr rd     cv ci    b  | ts td     mole   hit    st    err
    vecs[0]  = mk(0, 0, 8'h00, 0, 3'd0, 0,  0, 8'h00, 5'h00, 8'd0, 2'd0, 0);
    vecs[1]  = mk(1, 0, 8'h00, 0, 3'd0, 0,  0, 8'h00, 5'h00, 8'd0, 2'd1, 0);
    vecs[2]  = mk(0, 0, 8'h00, 0, 3'd0, 0,  1, 8'h53, 5'h00, 8'd0, 2'd1, 0);
    vecs[3]  = mk(0, 1, 8'h33, 0, 3'd0, 0,  0, 8'h00, 5'h08, 8'd0, 2'd2, 0);
    vecs[4]  = mk(0, 0, 8'h00, 1, 3'd3, 0,  0, 8'h00, 5'h08, 8'd0, 2'd2, 0);
    vecs[5]  = mk(0, 0, 8'h00, 1, 3'd3, 0,  1, 8'h48, 5'h08, 8'd0, 2'd2, 0);
    vecs[6]  = mk(0, 0, 8'h00, 0, 3'd0, 0,  0, 8'h00, 5'h08, 8'd0, 2'd2, 0);
    vecs[7]  = mk(0, 1, 8'h48, 0, 3'd0, 0,  0, 8'h00, 5'h08, 8'd1, 2'd2, 0);
    vecs[8]  = mk(0, 0, 8'h00, 1, 3'd3, 0,  0, 8'h00, 5'h08, 8'd1, 2'd2, 0);
    vecs[9]  = mk(0, 1, 8'h37, 0, 3'd0, 0,  0, 8'h00, 5'h08, 8'd1, 2'd2, 1);
    vecs[10] = mk(0, 1, 8'h53, 0, 3'd0, 0,  0, 8'h00, 5'h08, 8'd1, 2'd2, 1);
    vecs[11] = mk(0, 0, 8'h00, 1, 3'd2, 0,  0, 8'h00, 5'h08, 8'd1, 2'd2, 1);
    vecs[12] = mk(0, 1, 8'h31, 0, 3'd0, 0,  0, 8'h00, 5'h02, 8'd1, 2'd2, 1);
    vecs[13] = mk(0, 1, 8'h34, 1, 3'd1, 0,  0, 8'h00, 5'h10, 8'd1, 2'd2, 1);
    vecs[14] = mk(0, 0, 8'h00, 0, 3'd0, 0,  1, 8'h48, 5'h10, 8'd1, 2'd2, 1);
    vecs[15] = mk(0, 0, 8'h00, 1, 3'd4, 0,  0, 8'h00, 5'h10, 8'd1, 2'd2, 1);
    vecs[16] = mk(0, 0, 8'h00, 0, 3'd0, 0,  0, 8'h00, 5'h10, 8'd1, 2'd2, 1);
    vecs[17] = mk(0, 0, 8'h00, 0, 3'd0, 0,  1, 8'h48, 5'h10, 8'd1, 2'd2, 1);
    vecs[18] = mk(0, 1, 8'h52, 0, 3'd0, 0,  0, 8'h00, 5'h00, 8'd1, 2'd3, 1);
    vecs[19] = mk(0, 1, 8'h48, 1, 3'd4, 0,  0, 8'h00, 5'h00, 8'd1, 2'd3, 1);
    vecs[20] = mk(0, 0, 8'h00, 0, 3'd0, 0,  0, 8'h00, 5'h00, 8'd1, 2'd3, 1);
    vecs[21] = mk(1, 1, 8'h32, 0, 3'd0, 0,  0, 8'h00, 5'h04, 8'd0, 2'd2, 0);
    vecs[22] = mk(0, 0, 8'h00, 0, 3'd0, 0,  1, 8'h53, 5'h04, 8'd0, 2'd2, 0);
    vecs[23] = mk(1, 0, 8'h00, 0, 3'd0, 0,  0, 8'h00, 5'h04, 8'd0, 2'd2, 0);
    vecs[24] = mk(0, 0, 8'h00, 0, 3'd0, 0,  0, 8'h00, 5'h04, 8'd0, 2'd2, 0);
    vecs[25] = mk(0, 1, 8'h52, 0, 3'd0, 0,  0, 8'h00, 5'h00, 8'd0, 2'd3, 0);
    vecs[26] = mk(1, 0, 8'h00, 0, 3'd0, 0,  0, 8'h00, 5'h00, 8'd0, 2'd1, 0);
    vecs[27] = mk(0, 1, 8'h52, 0, 3'd0, 0,  1, 8'h53, 5'h00, 8'd0, 2'd3, 1);
    vecs[28] = mk(0, 0, 8'h00, 0, 3'd0, 0,  0, 8'h00, 5'h00, 8'd0, 2'd3, 1);

    reset = 1'b0;
    drive(0, 0, 8'h00, 0, 3'd0, 0);
    cyc();
    cyc();
    chk_all_zero("reset");
    reset = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].s, vecs[i].rr, vecs[i].rd, vecs[i].cv, vecs[i].ci, vecs[i].b);
      cyc();
      chk($sformatf("vec%0d_tx_start", i), 32'(tx_start), 32'(vecs[i].ts));
      if (vecs[i].ts) chk($sformatf("vec%0d_tx_data", i), 32'(tx_data), 32'(vecs[i].td));
      chk($sformatf("vec%0d_mole", i), 32'(mole_onehot), 32'(vecs[i].mole));
      chk($sformatf("vec%0d_hit", i), 32'(hit_count), 32'(vecs[i].hit));
      chk($sformatf("vec%0d_state", i), 32'(link_state), 32'(vecs[i].st));
      chk($sformatf("vec%0d_err", i), 32'(proto_err), 32'(vecs[i].err));
    end

    // Start timeout with no reply from the remote side.
    drive(1, 0, 8'h00, 0, 3'd0, 0);
    cyc();
    chk("tmo_start_state", 32'(link_state), 32'd1);
    chk("tmo_start_err", 32'(proto_err), 32'd0);
    drive(0, 0, 8'h00, 0, 3'd0, 0);
    repeat (8) cyc();
    chk("tmo_still_starting", 32'(link_state), 32'd1);
    repeat (2) cyc();
    chk("tmo_state_idle", 32'(link_state), 32'd0);
    chk("tmo_err", 32'(proto_err), 32'd1);

    // Hit counter saturation followed by end of game.
    drive(1, 0, 8'h00, 0, 3'd0, 0);
    cyc();
    drive(0, 1, 8'h30, 0, 3'd0, 0);
    cyc();
    chk("sat_playing", 32'(link_state), 32'd2);
    chk("sat_mole0", 32'(mole_onehot), 32'h01);
    drive(0, 1, 8'h48, 0, 3'd0, 0);
    repeat (300) cyc();
    chk("sat_hit255", 32'(hit_count), 32'd255);
    chk("sat_err_clear", 32'(proto_err), 32'd0);
    drive(0, 1, 8'h52, 0, 3'd0, 0);
    cyc();
    chk("sat_over_state", 32'(link_state), 32'd3);
    chk("sat_over_mole", 32'(mole_onehot), 32'd0);
    chk("sat_over_hit", 32'(hit_count), 32'd255);
    drive(0, 1, 8'h37, 0, 3'd0, 0);
    cyc();
    chk("sat_bad_digit_err", 32'(proto_err), 32'd1);

    // Queue overflow while the transmitter is busy, then in-order drain.
    drive(1, 0, 8'h00, 0, 3'd0, 0);
    cyc();
    drive(0, 1, 8'h30, 0, 3'd0, 0);
    cyc();
    drive(0, 0, 8'h00, 0, 3'd0, 0);
    repeat (5) cyc();
    starts = 0;
    drive(0, 0, 8'h00, 1, 3'd0, 1); cyc(); starts += int'(tx_start);
    drive(0, 1, 8'h31, 0, 3'd0, 1); cyc(); starts += int'(tx_start);
    drive(0, 0, 8'h00, 1, 3'd1, 1); cyc(); starts += int'(tx_start);
    drive(0, 1, 8'h32, 0, 3'd0, 1); cyc(); starts += int'(tx_start);
    chk("ovf_no_err_yet", 32'(proto_err), 32'd0);
    drive(0, 0, 8'h00, 1, 3'd2, 1); cyc(); starts += int'(tx_start);
    chk("ovf_err", 32'(proto_err), 32'd1);
    chk("ovf_no_tx_while_busy", 32'(starts), 32'd0);
    drive(0, 0, 8'h00, 0, 3'd0, 0);
    starts = 0; first_at = -1; last_at = -100; min_gap = 1000;
    for (int c = 0; c < 20; c++) begin
      cyc();
      if (tx_start) begin
        if (starts < 2) bytes_seen[starts] = tx_data;
        if (first_at < 0) first_at = c;
        else if (c - last_at < min_gap) min_gap = c - last_at;
        last_at = c;
        starts++;
      end
    end
    chk("ovf_drain_count", 32'(starts), 32'd2);
    chk("ovf_drain_first_cycle", 32'(first_at), 32'd0);
    chk("ovf_byte0", 32'(bytes_seen[0]), 32'h48);
    chk("ovf_byte1", 32'(bytes_seen[1]), 32'h48);
    chk("ovf_gap_ge3", 32'(min_gap >= 3), 32'd1);

    // Reset with two bytes queued behind a busy transmitter.
    drive(0, 1, 8'h48, 0, 3'd0, 1); cyc();
    drive(0, 1, 8'h33, 0, 3'd0, 1); cyc();
    drive(0, 0, 8'h00, 1, 3'd3, 1); cyc();
    drive(0, 1, 8'h34, 0, 3'd0, 1); cyc();
    drive(0, 0, 8'h00, 1, 3'd4, 1); cyc();
    chk("rst_pre_hit", 32'(hit_count), 32'd1);
    chk("rst_pre_mole", 32'(mole_onehot), 32'h10);
    drive(0, 0, 8'h00, 0, 3'd0, 0);
    reset = 1'b0;
    #1;
    chk_all_zero("rst_async");
    cyc();
    chk_all_zero("rst_held");
    reset = 1'b1;
    starts = 0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      starts += int'(tx_start);
    end
    chk("rst_no_tx_after_release", 32'(starts), 32'd0);
    chk("rst_idle_after_release", 32'(link_state), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mole_link_host.md
MOLE_LINK_HOST -- requirements
Module: mole_link_host

Interface
REQ-001 SHALL have parameter START_TIMEOUT, default 200_000_000, meaning clock cycles allowed between 'S' issue and first mole digit.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning TX command queue entries; legal values are 2 and 4 only.
REQ-003 SHALL have port clock, input, 1, system clock; all logic rising-edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port rx_data, input, 8, received byte from the UART receiver.
REQ-006 SHALL have port rx_ready, input, 1, one-cycle strobe qualifying rx_data.
REQ-007 SHALL have port tx_busy, input, 1, UART transmitter busy.
REQ-008 SHALL have port tx_start, output, 1, one-cycle transmit request.
REQ-009 SHALL have port tx_data, output, 8, byte to transmit; valid while tx_start is high.
REQ-010 SHALL have port start_req, input, 1, one-cycle local start request.
REQ-011 SHALL have port click_valid, input, 1, one-cycle local mole click.
REQ-012 SHALL have port click_idx, input, 3, clicked mole index 0..4.
REQ-013 SHALL have port mole_onehot, output, 5, current mole one-hot; 0 when none.
REQ-014 SHALL have port hit_count, output, 8, confirmed hits this game.
REQ-015 SHALL have port link_state, output, 2, 0=IDLE, 1=STARTING, 2=PLAYING, 3=OVER.
REQ-016 SHALL have port proto_err, output, 1, sticky protocol/overflow error.

Function
REQ-017 Byte codes SHALL be 'S'=0x53, 'H'=0x48, 'R'=0x52, digits '0'..'4'=0x30..0x34.
REQ-018 In IDLE or OVER, start_req SHALL push 'S', clear hit_count, mole_onehot and proto_err, load the timeout counter, and enter STARTING on the next edge.
REQ-019 start_req in STARTING or PLAYING SHALL be ignored.
REQ-020 In STARTING, an rx digit '0'..'4' SHALL set mole_onehot = 1<<digit and enter PLAYING.
REQ-021 In STARTING, timeout counter reaching 0 SHALL enter IDLE and set proto_err.
REQ-022 In PLAYING, an rx digit SHALL replace mole_onehot and re-arm the one-hit-per-appearance flag.
REQ-023 In PLAYING, rx 'H' SHALL increment hit_count, saturating at 255.
REQ-024 rx 'R' in PLAYING SHALL enter OVER and clear mole_onehot; hit_count SHALL hold.
REQ-025 rx 'R' in STARTING SHALL enter OVER and set proto_err.
REQ-026 Any rx byte outside the codes of REQ-017, including 0x35..0x39, SHALL set proto_err and be otherwise ignored.
REQ-027 rx 'S' SHALL be ignored without error.
REQ-028 In PLAYING, click_valid with click_idx matching the current mole, mole_onehot non-zero and the flag armed SHALL push 'H' and disarm the flag.
REQ-029 Mismatched clicks, repeat clicks, and clicks outside PLAYING SHALL be ignored.
REQ-030 A click and an rx digit in the same cycle SHALL evaluate the click against the pre-update mole.
REQ-031 The TX queue SHALL be FIFO_DEPTH deep and in-order.
REQ-032 A push to a full queue SHALL be dropped and SHALL set proto_err.
REQ-033 A simultaneous push and pop SHALL be allowed when the queue is full.
REQ-034 tx_start SHALL pulse for exactly one cycle when the queue is non-empty, tx_busy=0 and the guard counter is 0; the head SHALL be popped in that cycle.
REQ-035 After each tx_start, a 2-cycle guard SHALL block the next issue, covering the transmitter's busy latency.
REQ-036 A push at edge N with an empty queue, tx_busy=0 and guard=0 SHALL produce tx_start high in cycle N+1.
REQ-037 rx_ready coinciding with start_req SHALL process start_req first; the rx byte SHALL be evaluated in STARTING.

Reset
REQ-038 While reset is low, all outputs SHALL be 0: tx_start, tx_data, mole_onehot, hit_count, link_state=IDLE, proto_err.
REQ-039 While reset is low, the queue SHALL be empty, the guard counter 0, the timeout counter 0 and the flag disarmed.
REQ-040 Reset asserted mid-transmission SHALL discard queued bytes; no tx_start SHALL occur until a new push after release.

Verification
REQ-041 start_req, tx_busy=0 -> tx_start one cycle later with tx_data=0x53; link_state=1.
REQ-042 rx '3' then click_idx=3 twice -> mole_onehot=01000; exactly one tx_start with 0x48; rx 'H' gives hit_count=1.
REQ-043 tx_busy held high; three matching clicks across fresh moles '0','1','2' with FIFO_DEPTH=2 -> proto_err=1 and two queued 'H'. After tx_busy falls, the 'H' bytes are sent in order, spaced by at least 3 cycles.
REQ-044 Set START_TIMEOUT=10; start_req with no rx -> link_state=0 and proto_err=1 after 10 cycles.
REQ-045 In PLAYING with 300 rx 'H' then rx 'R' -> hit_count=255, link_state=3, mole_onehot=0; rx 0x37 -> proto_err=1.
REQ-046 Reset asserted with 2 queued bytes -> all outputs 0; no tx_start for 20 cycles after release.
